nmcu_core: RTL

One near-memory compute unit. It is instantiated NUM_NMCUS times beneath the NMCU controller, and each instance consumes the controller's broadcast of descriptors, kernels and inputs. Each instance computes exactly one output pixel: a stride-1, unpadded convolution with optional ReLU. It then requests a write of that result through the controller's per-unit handshake.

---
 rtl/nmcu_pkg.sv | 46 ++++
 rtl/nmcu_window_mac.sv | 41 ++++
 rtl/nmcu_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nmcu_pkg.sv
// Shared types and descriptor field positions for the near-memory compute units
// and their controller.
package nmcu_pkg;

   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      READ_DESCS   = 4'd1,
      READ_KERNELS = 4'd2,
      READ_INPUTS  = 4'd3,
      COMPUTE      = 4'd4,
      WRITE        = 4'd5,
      DONE         = 4'd6
   } state_t;

   typedef enum logic [1:0] {
      NOP  = 2'd0,
      CONV = 2'd1,
      MAXP = 2'd2,
      RELU = 2'd3
   } layer_type_t;

   localparam int TYPE_LSB   = 0;
   localparam int TYPE_MSB   = 1;
   localparam int WIDTH_LSB  = 2;
   localparam int WIDTH_MSB  = 5;
   localparam int HEIGHT_LSB = 6;
   localparam int HEIGHT_MSB = 9;
   localparam int KSIZE_LSB  = 10;
   localparam int KSIZE_MSB  = 12;
   localparam int KADDR_LSB  = 16;
   localparam int KADDR_MSB  = 31;

   // Wide enough for pixel coordinates, word counts and kernel totals.
   localparam int COORD_W = 10;

   // Only the fields a unit acts on are retained from each descriptor.
   typedef struct packed {
      layer_type_t kind;
      logic [2:0]  ksize;
   } desc_t;

   function automatic logic [COORD_W-1:0] ksq(input logic [2:0] k);
      return COORD_W'(k) * COORD_W'(k);
   endfunction

endpackage

// File: rtl/nmcu_window_mac.sv
// Window hit test, kernel index and signed multiply-accumulate for one output pixel.
module nmcu_window_mac
   import nmcu_pkg::*;
#(
   parameter int DATABUS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     en,
   input  logic [COORD_W-1:0]       row,
   input  logic [COORD_W-1:0]       col,
   input  logic [COORD_W-1:0]       out_row,
   input  logic [COORD_W-1:0]       out_col,
   input  logic [COORD_W-1:0]       ksize,
   input  logic [DATABUS_WIDTH-1:0] in_word,
   input  logic [DATABUS_WIDTH-1:0] kern_word,
   output logic [COORD_W-1:0]       kidx,
   output logic [DATABUS_WIDTH-1:0] acc
);

   logic                     hit;
   logic [DATABUS_WIDTH-1:0] prod;

   assign hit  = (row >= out_row) && (row < out_row + ksize) &&
                 (col >= out_col) && (col < out_col + ksize);
   assign kidx = (row - out_row) * ksize + (col - out_col);
   // Low half of the product is the same for signed and unsigned operands.
   assign prod = $signed(in_word) * $signed(kern_word);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en && hit) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/nmcu_core.sv
// One near-memory compute unit: consumes the broadcast descriptor/kernel/input
// stream and writes back the single convolution output pixel it owns.
module nmcu_core
   import nmcu_pkg::*;
#(
   parameter int NMCU_ID        = 0,
   parameter int DATABUS_WIDTH  = 32,
   parameter int MAX_DESCS      = 8,
   parameter int MAX_INPUT_DIM  = 15,
   parameter int MAX_KERNEL_DIM = 7
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [$clog2(MAX_INPUT_DIM):0]     full_input_width,
   input  logic [$clog2(MAX_INPUT_DIM):0]     full_input_height,
   output logic [3:0]                         state,
   output logic                               mem_sel,
   output logic                               mem_w,
   input  logic                               mem_ready,
   inout  wire  [DATABUS_WIDTH-1:0]           data_bus
);

   localparam int DIM_W = $clog2(MAX_INPUT_DIM) + 1;
   localparam int DC_W  = $clog2(MAX_DESCS) + 1;
   localparam int DI_W  = $clog2(MAX_DESCS);
   localparam int KN    = MAX_KERNEL_DIM * MAX_KERNEL_DIM;
   localparam int KI_W  = $clog2(KN);
   localparam logic [DC_W-1:0]    LAST_DESC = DC_W'(MAX_DESCS - 1);
   localparam logic [COORD_W-1:0] UNIT_ID   = COORD_W'(NMCU_ID);

   state_t                   st;
   desc_t                    desc [MAX_DESCS];
   logic [DC_W-1:0]          desc_cnt;
   logic [COORD_W-1:0]       kern_cnt;
   logic [DATABUS_WIDTH-1:0] kernel [KN];
   logic [DIM_W-1:0]         in_w, in_h;
   logic [COORD_W-1:0]       row, col;
   logic [DATABUS_WIDTH-1:0] result;

   logic                     take;
   desc_t                    cur;
   logic [COORD_W-1:0]       scan_total, cur_total, kk_first;
   logic [2:0]               first_k;
   logic                     has_conv, relu_after;
   logic [COORD_W-1:0]       k_c, w_c, h_c, out_w, out_h, out_row, out_col;
   logic                     geom_ok, active, last_in, mac_en;
   logic [COORD_W-1:0]       kidx;
   logic [DATABUS_WIDTH-1:0] kern_word, acc;

   assign state = st;
   assign take  = mem_ready && mem_sel && !mem_w;
   assign cur   = '{kind: layer_type_t'(data_bus[TYPE_MSB:TYPE_LSB]),
                    ksize: data_bus[KSIZE_MSB:KSIZE_LSB]};
   assign data_bus = (mem_sel && mem_w) ? result : {DATABUS_WIDTH{1'bz}};

   // Summary of the descriptors stored so far; entries past desc_cnt are stale.
   always_comb begin
      scan_total = '0;
      first_k    = '0;
      has_conv   = 1'b0;
      relu_after = 1'b0;
      for (int i = 0; i < MAX_DESCS; i++) begin
         if (i < int'(desc_cnt)) begin
            if (desc[i].kind == CONV) begin
               scan_total = scan_total + ksq(desc[i].ksize);
               if (!has_conv) begin
                  first_k  = desc[i].ksize;
                  has_conv = 1'b1;
               end
            end else if (desc[i].kind == RELU && has_conv) begin
               relu_after = 1'b1;
            end
         end
      end
   end

   assign cur_total = scan_total + ((cur.kind == CONV) ? ksq(cur.ksize) : '0);
   assign kk_first  = ksq(first_k);

   always_comb begin
      k_c     = COORD_W'(first_k);
      w_c     = COORD_W'(in_w);
      h_c     = COORD_W'(in_h);
      geom_ok = has_conv && (first_k != 3'd0) && (k_c <= w_c) && (k_c <= h_c);
      out_w   = geom_ok ? (w_c - k_c + 1'b1) : COORD_W'(1);
      out_h   = geom_ok ? (h_c - k_c + 1'b1) : COORD_W'(1);
      out_row = UNIT_ID / out_w;
      out_col = UNIT_ID % out_w;
      active  = geom_ok && (UNIT_ID < out_w * out_h);
      last_in = (row == h_c - 1'b1) && (col == w_c - 1'b1);
   end

   assign mac_en    = take && (st == READ_INPUTS) && geom_ok;
   assign kern_word = (kidx < COORD_W'(KN)) ? kernel[kidx[KI_W-1:0]] : '0;

   nmcu_window_mac #(
      .DATABUS_WIDTH(DATABUS_WIDTH)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clear    (st == IDLE),
      .en       (mac_en),
      .row      (row),
      .col      (col),
      .out_row  (out_row),
      .out_col  (out_col),
      .ksize    (k_c),
      .in_word  (data_bus),
      .kern_word(kern_word),
      .kidx     (kidx),
      .acc      (acc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= IDLE;
         mem_sel  <= 1'b0;
         mem_w    <= 1'b0;
         desc_cnt <= '0;
         kern_cnt <= '0;
         row      <= '0;
         col      <= '0;
         in_w     <= '0;
         in_h     <= '0;
         result   <= '0;
         for (int i = 0; i < MAX_DESCS; i++) desc[i] <= '0;
         for (int i = 0; i < KN; i++) kernel[i] <= '0;
      end else begin
         case (st)
            IDLE: begin
               desc_cnt <= '0;
               kern_cnt <= '0;
               row      <= '0;
               col      <= '0;
               if (start) begin
                  st      <= READ_DESCS;
                  mem_sel <= 1'b1;
                  mem_w   <= 1'b0;
               end
            end
            READ_DESCS: if (take) begin
               desc[desc_cnt[DI_W-1:0]] <= cur;
               desc_cnt <= desc_cnt + 1'b1;
               if (cur.kind == NOP || desc_cnt == LAST_DESC) begin
                  if (cur_total == '0) begin
                     st   <= READ_INPUTS;
                     in_w <= full_input_width;
                     in_h <= full_input_height;
                  end else begin
                     st <= READ_KERNELS;
                  end
               end
            end
            READ_KERNELS: if (take) begin
               // Only the first CONV's kernel is kept; later kernels are skipped.
               if (kern_cnt < kk_first) kernel[kern_cnt[KI_W-1:0]] <= data_bus;
               kern_cnt <= kern_cnt + 1'b1;
               if (kern_cnt == scan_total - 1'b1) begin
                  st   <= READ_INPUTS;
                  in_w <= full_input_width;
                  in_h <= full_input_height;
               end
            end
            READ_INPUTS: if (take) begin
               if (col == w_c - 1'b1) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
               if (last_in) begin
                  mem_sel <= 1'b0;
                  st      <= active ? COMPUTE : DONE;
               end
            end
            COMPUTE: begin
               result  <= (relu_after && acc[DATABUS_WIDTH-1]) ? '0 : acc;
               st      <= WRITE;
               mem_sel <= 1'b1;
               mem_w   <= 1'b1;
            end
            WRITE: if (mem_ready) begin
               st      <= DONE;
               mem_sel <= 1'b0;
               mem_w   <= 1'b0;
            end
            DONE: if (!start) st <= IDLE;
            default: begin
               st      <= IDLE;
               mem_sel <= 1'b0;
               mem_w   <= 1'b0;
            end
         endcase
      end
   end

endmodule
